pie_frame_encoder: RTL and testbench

PIE_FRAME_ENCODER -- requirements
Module: pie_frame_encoder

---
 rtl/pie_frame_encoder.sv | 212 +++++++++++++++++++++
 tb/tb_pie_frame_encoder.sv | 257 +++++++++++++++++++++++++
 2 files changed

// File: rtl/pie_frame_encoder.sv
// PIE frame encoder: delimiter, data-0, RTcal, optional TRcal, then one PIE symbol per data bit.
// Define PIE_TRCAL_EN to honour start_pre and emit the TRcal preamble segment.
module pie_frame_encoder #(
  parameter int unsigned CNT_W = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic             start_pre,
  input  logic [CNT_W-1:0] tari,
  input  logic [CNT_W-1:0] pw,
  input  logic [CNT_W-1:0] data1_len,
  input  logic [CNT_W-1:0] rtcal,
  input  logic [CNT_W-1:0] trcal,
  input  logic [CNT_W-1:0] delim,
  input  logic             in_bit,
  input  logic             in_last,
  input  logic             in_valid,
  output logic             in_rdy,
  input  logic             out_rdy,
  output logic             out_pie,
  output logic             busy,
  output logic             done,
  output logic             underrun
);

  typedef enum logic [2:0] {
    S_IDLE,
    S_DELIM,
    S_DATA0,
    S_RTCAL,
`ifdef PIE_TRCAL_EN
    S_TRCAL,
`endif
    S_DATA,
    S_WAIT
  } state_t;

  localparam logic [CNT_W-1:0] ONE = CNT_W'(1);

  state_t           state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [CNT_W-1:0] len_q, len_d;
  logic [CNT_W-1:0] tari_q, pw_q, d1_q, rtcal_q;
  logic             last_q, last_d;
  logic             pie_q, pie_d;
  logic             rdy_q, rdy_d;
  logic             busy_q, busy_d;
  logic             done_q, done_d;
  logic             ur_q, ur_d;
  logic             seg_end, slot_req, slot_seg;

`ifdef PIE_TRCAL_EN
  logic [CNT_W-1:0] trcal_q;
  logic             pre_q;
`else
  logic             unused_cfg;
  assign unused_cfg = ^{start_pre, trcal};
`endif

  function automatic logic [CNT_W-1:0] nz(input logic [CNT_W-1:0] v);
    return (v == '0) ? ONE : v;
  endfunction

  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    len_d    = len_q;
    last_d   = last_q;
    busy_d   = busy_q;
    done_d   = 1'b0;
    ur_d     = ur_q;
    slot_req = 1'b0;
    seg_end  = (cnt_q == len_q - ONE);

    if (state_q == S_IDLE) begin
      if (start) begin
        state_d = S_DELIM;
        cnt_d   = '0;
        len_d   = nz(delim);
        last_d  = 1'b0;
        busy_d  = 1'b1;
        ur_d    = 1'b0;
      end
    end else if (out_rdy) begin
      if (state_q == S_WAIT) begin
        slot_req = 1'b1;
      end else if (!seg_end) begin
        cnt_d = cnt_q + ONE;
      end else begin
        cnt_d = '0;
        case (state_q)
          S_DELIM: begin
            state_d = S_DATA0;
            len_d   = tari_q;
          end
          S_DATA0: begin
            state_d = S_RTCAL;
            len_d   = rtcal_q;
          end
          S_RTCAL: begin
`ifdef PIE_TRCAL_EN
            if (pre_q) begin
              state_d = S_TRCAL;
              len_d   = trcal_q;
            end else begin
              slot_req = 1'b1;
            end
`else
            slot_req = 1'b1;
`endif
          end
`ifdef PIE_TRCAL_EN
          S_TRCAL: slot_req = 1'b1;
`endif
          S_DATA: begin
            if (last_q) begin
              state_d = S_IDLE;
              busy_d  = 1'b0;
              done_d  = 1'b1;
            end else begin
              slot_req = 1'b1;
            end
          end
          default: ;
        endcase
      end

      // Data slot: an offered bit starts its symbol at once, otherwise stall high in WAIT.
      if (slot_req) begin
        cnt_d = '0;
        if (in_valid) begin
          state_d = S_DATA;
          len_d   = in_bit ? d1_q : tari_q;
          last_d  = in_last;
        end else begin
          state_d = S_WAIT;
          ur_d    = 1'b1;
        end
      end
    end

    // Outputs are derived from the next position so they register in step with it.
    pie_d    = 1'b1;
    rdy_d    = 1'b0;
    slot_seg = 1'b0;
    case (state_d)
      S_IDLE:  ;
      S_DELIM: pie_d = 1'b0;
      S_WAIT:  rdy_d = 1'b1;
      default: begin
        pie_d = (pw_q < len_d) && (cnt_d < len_d - pw_q);
`ifdef PIE_TRCAL_EN
        slot_seg = (state_d == S_TRCAL) || ((state_d == S_RTCAL) && !pre_q) ||
                   ((state_d == S_DATA) && !last_d);
`else
        slot_seg = (state_d == S_RTCAL) || ((state_d == S_DATA) && !last_d);
`endif
        rdy_d = slot_seg && (cnt_d == len_d - ONE);
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= S_IDLE;
      cnt_q   <= '0;
      len_q   <= '0;
      last_q  <= 1'b0;
      pie_q   <= 1'b1;
      rdy_q   <= 1'b0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
      ur_q    <= 1'b0;
      tari_q  <= '0;
      pw_q    <= '0;
      d1_q    <= '0;
      rtcal_q <= '0;
`ifdef PIE_TRCAL_EN
      trcal_q <= '0;
      pre_q   <= 1'b0;
`endif
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      len_q   <= len_d;
      last_q  <= last_d;
      pie_q   <= pie_d;
      rdy_q   <= rdy_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
      ur_q    <= ur_d;
      if (state_q == S_IDLE && start) begin
        tari_q  <= nz(tari);
        pw_q    <= nz(pw);
        d1_q    <= nz(data1_len);
        rtcal_q <= nz(rtcal);
`ifdef PIE_TRCAL_EN
        trcal_q <= nz(trcal);
        pre_q   <= start_pre;
`endif
      end
    end
  end

  assign out_pie  = pie_q;
  assign busy     = busy_q;
  assign done     = done_q;
  assign underrun = ur_q;
  assign in_rdy   = rdy_q & out_rdy;

endmodule

// File: tb/tb_pie_frame_encoder.sv
// Scoreboard bench for pie_frame_encoder: frame waveforms predicted cycle by cycle from segment rules.
module tb_pie_frame_encoder;
  localparam int unsigned W = 8;

  logic         clk = 1'b0;
  logic         rst, start, start_pre, in_bit, in_last, in_valid, in_rdy, out_rdy;
  logic         out_pie, busy, done, underrun;
  logic [W-1:0] tari, pw, data1_len, rtcal, trcal, delim;

  always #5 clk = ~clk;

  pie_frame_encoder #(.CNT_W(W)) dut (
    .clk(clk), .rst(rst), .start(start), .start_pre(start_pre),
    .tari(tari), .pw(pw), .data1_len(data1_len), .rtcal(rtcal), .trcal(trcal), .delim(delim),
    .in_bit(in_bit), .in_last(in_last), .in_valid(in_valid), .in_rdy(in_rdy),
    .out_rdy(out_rdy), .out_pie(out_pie), .busy(busy), .done(done), .underrun(underrun)
  );

  typedef struct packed {
    logic pie;
    logic bsy;
    logic dn;
    logic rdy;
    logic ur;
  } exp_t;

  exp_t q[$];
  int unsigned n_cmp = 0, n_err = 0;

  // Frame description shared by the model and the driver
  int f_tari, f_pw, f_d1, f_rtcal, f_trcal, f_delim, f_nb;
  bit f_pre;
  bit f_bits[16];
  int f_gaps[16];

  function automatic int nz(input int v);
    return (v == 0) ? 1 : v;
  endfunction

  function automatic void push_e(input bit pie, input bit bsy, input bit dn, input bit rdy, input bit ur);
    exp_t e;
    e.pie = pie; e.bsy = bsy; e.dn = dn; e.rdy = rdy; e.ur = ur;
    q.push_back(e);
  endfunction

  // A segment of length L is high for L-p cycles then low for p cycles (all low if p >= L)
  function automatic void push_seg(input int L, input int p, input bit rdy_last, input bit ur);
    for (int c = 0; c < L; c++)
      push_e(c < (L - p), 1'b1, 1'b0, rdy_last && (c == L - 1), ur);
  endfunction

  function automatic void build_frame();
    bit ur = 1'b0;
    bit trc;
`ifdef PIE_TRCAL_EN
    trc = f_pre;
`else
    trc = 1'b0;
`endif
    push_seg(nz(f_delim), nz(f_delim), 1'b0, 1'b0);
    push_seg(nz(f_tari), nz(f_pw), 1'b0, 1'b0);
    push_seg(nz(f_rtcal), nz(f_pw), !trc, 1'b0);
    if (trc) push_seg(nz(f_trcal), nz(f_pw), 1'b1, 1'b0);
    for (int i = 0; i < f_nb; i++) begin
      for (int g = 0; g < f_gaps[i]; g++) begin
        ur = 1'b1;
        push_e(1'b1, 1'b1, 1'b0, 1'b1, 1'b1);
      end
      push_seg(f_bits[i] ? nz(f_d1) : nz(f_tari), nz(f_pw), i != f_nb - 1, ur);
    end
    push_e(1'b1, 1'b0, 1'b1, 1'b0, ur);
  endfunction

  // Monitor: advances the expectation on every edge the DUT was allowed to move
  exp_t cur;
  bit   in_frame = 0, armed = 0, prev_rst = 0, prev_start = 0, prev_ordy = 0;
  always @(negedge clk) begin
    exp_t e;
    logic [4:0] act;
    if (prev_rst) begin
      q.delete();
      in_frame = 0;
      cur = '0;
      cur.pie = 1'b1;
      armed = 1;
    end else if (!in_frame && prev_start) begin
      if (q.size() > 0) begin
        cur = q.pop_front();
        in_frame = 1;
      end else begin
        n_cmp++; n_err++;
        $display("FAIL start_pop: expectation queue empty at %0t", $time);
      end
    end else if (in_frame && prev_ordy) begin
      if (q.size() > 0) begin
        cur = q.pop_front();
        if (cur.dn) in_frame = 0;
      end else begin
        n_cmp++; n_err++;
        $display("FAIL frame_pop: expectation queue empty at %0t", $time);
      end
    end else if (!in_frame) begin
      cur.pie = 1'b1; cur.bsy = 1'b0; cur.dn = 1'b0; cur.rdy = 1'b0;
    end
    if (armed) begin
      e = cur;
      e.rdy = cur.rdy && out_rdy;
      act = {out_pie, busy, done, in_rdy, underrun};
      n_cmp++;
      if (act !== e) begin
        n_err++;
        $display("FAIL outputs t=%0t {pie,busy,done,in_rdy,underrun} got %b expected %b", $time, act, e);
      end
    end
    prev_rst = rst; prev_start = start; prev_ordy = out_rdy;
  end

  task automatic idle(input int n);
    repeat (n) begin
      @(posedge clk); #1;
      start = 0; rst = 0; in_valid = 0;
      out_rdy = 1'($urandom_range(0, 1));
    end
  endtask

  task automatic randomize_timing();
    tari = W'($urandom); pw = W'($urandom); data1_len = W'($urandom);
    rtcal = W'($urandom); trcal = W'($urandom); delim = W'($urandom);
    start_pre = 1'($urandom_range(0, 1));
  endtask

  // stall_mode: 0 none, 1 random, 2 five-cycle window mid-RTcal. rst_at>0 resets at that cycle.
  task automatic run_frame(input int stall_mode, input int rst_at, output int done_cyc);
    int cyc = 0, bi = 0, offers = 0;
    bit fin = 0;
    done_cyc = -1;
    @(posedge clk); #1;
    tari = W'(f_tari); pw = W'(f_pw); data1_len = W'(f_d1);
    rtcal = W'(f_rtcal); trcal = W'(f_trcal); delim = W'(f_delim);
    start_pre = f_pre; start = 1; out_rdy = 1; in_valid = 0;
    build_frame();
    while (!fin) begin
      @(posedge clk); #1;
      cyc++;
      start = (cyc == 2) || (cyc == rst_at);
      rst = (cyc == rst_at);
      if (cyc == 2) randomize_timing();
      case (stall_mode)
        1: out_rdy = ($urandom_range(0, 4) != 0);
        2: out_rdy = !(cyc >= 30 && cyc < 35);
        default: out_rdy = 1;
      endcase
      #1;
      if (rst_at > 0 && cyc > rst_at) begin
        fin = 1;
      end else if (done === 1'b1) begin
        fin = 1;
        done_cyc = cyc;
      end else if (cyc > 4000) begin
        n_cmp++; n_err++;
        $display("FAIL frame_timeout: no done after %0d cycles, required completion", cyc);
        fin = 1;
      end else if (bi < f_nb) begin
        in_valid = (offers >= f_gaps[bi]);
        in_bit = in_valid ? f_bits[bi] : 1'($urandom_range(0, 1));
        in_last = in_valid ? (bi == f_nb - 1) : 1'($urandom_range(0, 1));
        if (in_rdy === 1'b1) begin
          if (in_valid) begin
            bi++;
            offers = 0;
          end else begin
            offers++;
          end
        end
      end else begin
        in_valid = 0;
      end
    end
    in_valid = 0;
    start = 0;
    rst = 0;
  endtask

  task automatic set_directed(input bit pre, input int gap0);
    f_tari = 12; f_pw = 6; f_d1 = 20; f_rtcal = 32; f_trcal = 48; f_delim = 12;
    f_pre = pre; f_nb = 2;
    f_bits[0] = 0; f_bits[1] = 1;
    f_gaps[0] = gap0; f_gaps[1] = 0;
  endtask

  task automatic check_len(input string name, input int got, input int req);
    n_cmp++;
    if (got != req) begin
      n_err++;
      $display("FAIL %s: done at cycle %0d, required %0d", name, got, req);
    end
  endtask

  initial begin
    int dc, pre_len;
    rst = 1; start = 0; start_pre = 0; in_bit = 0; in_last = 0; in_valid = 0; out_rdy = 1;
    tari = '0; pw = '0; data1_len = '0; rtcal = '0; trcal = '0; delim = '0;
    repeat (3) @(posedge clk);
    #1 rst = 0;
    idle(2);

    set_directed(0, 0); run_frame(0, 0, dc); check_len("framesync_len", dc, 89);
    idle(3);
    set_directed(0, 3); run_frame(0, 0, dc); check_len("underrun_len", dc, 92);
    idle(3);
    set_directed(0, 0); run_frame(2, 0, dc); check_len("stall_len", dc, 94);
    idle(3);
`ifdef PIE_TRCAL_EN
    pre_len = 137;
`else
    pre_len = 89;
`endif
    set_directed(1, 0); run_frame(0, 0, dc); check_len("preamble_len", dc, pre_len);
    idle(3);

    set_directed(0, 0); run_frame(0, 40, dc);
    idle(3);
    set_directed(0, 0); run_frame(0, 0, dc); check_len("post_reset_len", dc, 89);
    idle(3);

    for (int f = 0; f < 30; f++) begin
      f_tari = $urandom_range(0, 15); f_pw = $urandom_range(0, 15);
      f_d1 = $urandom_range(0, 15); f_rtcal = $urandom_range(0, 15);
      f_trcal = $urandom_range(0, 15); f_delim = $urandom_range(0, 15);
      f_pre = 1'($urandom_range(0, 1));
      f_nb = $urandom_range(1, 6);
      for (int i = 0; i < f_nb; i++) begin
        f_bits[i] = 1'($urandom_range(0, 1));
        f_gaps[i] = ($urandom_range(0, 3) == 0) ? $urandom_range(1, 3) : 0;
      end
      run_frame($urandom_range(0, 1), 0, dc);
      idle($urandom_range(2, 4));
    end

    idle(3);
    n_cmp++;
    if (q.size() != 0) begin
      n_err++;
      $display("FAIL queue_drain: %0d expectations left, required 0", q.size());
    end
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

  initial begin
    #3000000;
    $display("FAIL watchdog: simulation time limit reached, required completion");
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err + 1);
    $fatal(1, "watchdog");
  end

endmodule
